// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read arbiter: response codes, FSM states
// and the master index assignment.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int M_INST = 0;
  localparam int M_DATA = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker: round-robin away from the last owner, or fixed
// priority to the instruction master. Purely combinational.
module rr_arb2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  // A tie goes to the instruction master when fixed or when data owned last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt[M_INST] = 1'b1;
      2'b10: gnt[M_DATA] = 1'b1;
      2'b11: begin
        if (fixed_prio || last_grant) begin
          gnt[M_INST] = 1'b1;
        end else begin
          gnt[M_DATA] = 1'b1;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_arb.sv
// Two-master AXI read arbiter: serialises whole read bursts onto one slave
// port and flags bursts whose RLAST disagrees with the requested length.
module axi_rd_arb
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          m_arvalid,
  output logic [1:0]          m_arready,
  input  logic [2*ADDR_W-1:0] m_araddr,
  input  logic [2*LEN_W-1:0]  m_arlen,
  output logic [1:0]          m_rvalid,
  input  logic [1:0]          m_rready,
  output logic [DATA_W-1:0]   m_rdata,
  output logic [1:0]          m_rresp,
  output logic                m_rlast,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [LEN_W-1:0]    s_arlen,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  output logic [1:0]          grant,
  output logic                busy,
  output logic                len_err
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] exp_len_q, exp_len_d;
  logic             len_err_q, len_err_d;
  logic [1:0]       pick;
  logic             gidx;
  logic             ar_hs;
  logic             r_hs;

  rr_arb2 u_pick (
    .req        (m_arvalid),
    .last_grant (last_grant_q),
    .fixed_prio (FIXED_PRIO),
    .gnt        (pick)
  );

  assign gidx     = grant_q[M_DATA];
  assign s_araddr = gidx ? m_araddr[M_DATA*ADDR_W +: ADDR_W] : m_araddr[M_INST*ADDR_W +: ADDR_W];
  assign s_arlen  = gidx ? m_arlen[M_DATA*LEN_W +: LEN_W] : m_arlen[M_INST*LEN_W +: LEN_W];
  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;
  assign m_rlast  = s_rlast;
  assign ar_hs    = s_arvalid & s_arready;
  assign r_hs     = s_rvalid & s_rready;

  // Route handshakes between the owning master and the slave by phase.
  always_comb begin
    s_arvalid = 1'b0;
    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    s_rready  = 1'b0;
    case (state_q)
      ADDR: begin
        s_arvalid = m_arvalid[gidx];
        m_arready = grant_q & {2{s_arready}};
      end
      DATA: begin
        m_rvalid = grant_q & {2{s_rvalid}};
        s_rready = m_rready[gidx];
      end
      default: begin
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
      end
    endcase
  end

  // Transaction sequencing, beat counting and length checking.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    exp_len_d    = exp_len_q;
    len_err_d    = len_err_q;
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          grant_d = pick;
          state_d = ADDR;
        end else begin
          grant_d = 2'b00;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          exp_len_d  = s_arlen;
          beat_cnt_d = '0;
          state_d    = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (r_hs) begin
          if (beat_cnt_q != LEN_MAX) begin
            beat_cnt_d = beat_cnt_q + LEN_ONE;
          end else begin
            beat_cnt_d = beat_cnt_q;
          end
          if (s_rlast) begin
            len_err_d    = len_err_q | (beat_cnt_q != exp_len_q);
            last_grant_d = gidx;
            grant_d      = 2'b00;
            state_d      = IDLE;
          end else begin
            // The final expected beat arrived without RLAST.
            len_err_d = len_err_q | (beat_cnt_q == exp_len_q);
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State registers; last_grant resets to the data master so instruction wins the first tie.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      exp_len_q    <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      exp_len_q    <= exp_len_d;
      len_err_q    <= len_err_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Randomised bench for axi_rd_arb: bus-functional masters and slave, a
// transaction-level expectation of the arbiter, plus a fixed-priority instance.
module tb_axi_rd_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic clk;
  logic rst;

  logic [1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_rresp, s_rresp, grant;
  logic [2*AW-1:0] m_araddr;
  logic [2*LW-1:0] m_arlen;
  logic [DW-1:0] m_rdata, s_rdata;
  logic          m_rlast, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, busy, len_err;
  logic [AW-1:0] s_araddr;
  logic [LW-1:0] s_arlen;

  logic [1:0]    f_m_arvalid, f_m_arready, f_m_rvalid, f_m_rready, f_m_rresp, f_s_rresp, f_grant;
  logic [2*AW-1:0] f_m_araddr;
  logic [2*LW-1:0] f_m_arlen;
  logic [DW-1:0] f_m_rdata, f_s_rdata;
  logic          f_m_rlast, f_s_arvalid, f_s_arready, f_s_rvalid, f_s_rready, f_s_rlast, f_busy, f_len_err;
  logic [AW-1:0] f_s_araddr;
  logic [LW-1:0] f_s_arlen;

  axi_rd_arb #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIXED_PRIO(1'b0)) dut (
    .CLK(clk), .RST(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  axi_rd_arb #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIXED_PRIO(1'b1)) dut_fp (
    .CLK(clk), .RST(rst),
    .m_arvalid(f_m_arvalid), .m_arready(f_m_arready), .m_araddr(f_m_araddr), .m_arlen(f_m_arlen),
    .m_rvalid(f_m_rvalid), .m_rready(f_m_rready), .m_rdata(f_m_rdata), .m_rresp(f_m_rresp), .m_rlast(f_m_rlast),
    .s_arvalid(f_s_arvalid), .s_arready(f_s_arready), .s_araddr(f_s_araddr), .s_arlen(f_s_arlen),
    .s_rvalid(f_s_rvalid), .s_rready(f_s_rready), .s_rdata(f_s_rdata), .s_rresp(f_s_rresp), .s_rlast(f_s_rlast),
    .grant(f_grant), .busy(f_busy), .len_err(f_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests, n_fail;

  // master side: pending AR and the burst each master is currently receiving
  bit          mp_pend [2];
  logic [31:0] mp_addr [2];
  int          mp_len  [2];
  logic [31:0] mb_addr [2];
  int          mb_beat [2];
  int          n_beats [2];
  logic [31:0] last_data [2];

  // slave side
  bit          sl_busy, sl_rv, sl_early, err_done;
  logic [31:0] sl_addr;
  int          sl_len, sl_beat;

  // knobs
  int          p_req, p_rr, p_sar, p_sr, min_len, max_len;
  logic [1:0]  req_mask;
  bit          inj_err, rec_grants, rst_arm, rst_hit;

  // expectation: who is being served, whether its address was accepted, beats delivered
  int          md_owner, md_beats, md_len, md_last;
  bit          md_data, md_err;
  logic [1:0]  prev_grant;
  logic [1:0]  grant_seq [$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit roll(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a, input int b);
    logic [31:0] k;
    k = 32'(b + 1);
    if (a == 32'h0000_0100 && b == 0) return 32'hDEAD_BEEF;
    return a ^ (32'h9E37_79B9 * k);
  endfunction

  task automatic reset_env();
    for (int i = 0; i < 2; i++) begin
      mp_pend[i] = 1'b0; mp_addr[i] = 32'h0; mp_len[i] = 0; mb_beat[i] = 0; mb_addr[i] = 32'h0;
    end
    sl_busy = 1'b0; sl_rv = 1'b0; sl_early = 1'b0; sl_addr = 32'h0; sl_len = 0; sl_beat = 0;
    md_owner = -1; md_data = 1'b0; md_beats = 0; md_len = 0; md_last = 1; md_err = 1'b0;
    prev_grant = 2'b00;
  endtask

  task automatic step();
    logic [1:0] e_grant, e_arrdy, e_rvalid;
    logic       e_sarv, e_srrdy;
    int         o, delivered;
    bit         ar_hs, r_hs;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      m_arvalid[i]         = mp_pend[i];
      m_araddr[i*AW +: AW] = mp_addr[i];
      m_arlen[i*LW +: LW]  = LW'(mp_len[i]);
      m_rready[i]          = roll(p_rr);
    end
    s_arready = !sl_busy && roll(p_sar);
    if (sl_busy && !sl_rv && roll(p_sr)) sl_rv = 1'b1;
    s_rvalid = sl_rv;
    s_rdata  = data_of(sl_addr, sl_beat);
    s_rlast  = sl_rv && ((sl_beat == sl_len) || (sl_early && sl_beat == 0));
    s_rresp  = 2'b00;
    #1;
    o        = (md_owner < 0) ? 0 : md_owner;
    e_grant  = (md_owner < 0) ? 2'b00 : ((o == 1) ? 2'b10 : 2'b01);
    e_sarv   = (md_owner >= 0) && !md_data && m_arvalid[o];
    e_arrdy  = ((md_owner >= 0) && !md_data && s_arready) ? e_grant : 2'b00;
    e_rvalid = (md_data && s_rvalid) ? e_grant : 2'b00;
    e_srrdy  = md_data && m_rready[o];
    check_val("grant", grant, e_grant);
    check_val("busy", busy, md_owner >= 0);
    check_val("len_err", len_err, md_err);
    check_val("s_arvalid", s_arvalid, e_sarv);
    check_val("m_arready", m_arready, e_arrdy);
    check_val("m_rvalid", m_rvalid, e_rvalid);
    check_val("s_rready", s_rready, e_srrdy);
    if (e_sarv) begin
      check_val("s_araddr", s_araddr, mp_addr[o]);
      check_val("s_arlen", s_arlen, mp_len[o]);
    end
    if (md_data) begin
      check_val("m_rdata", m_rdata, s_rdata);
      check_val("m_rlast", m_rlast, s_rlast);
    end
    if (rec_grants && grant != 2'b00 && prev_grant == 2'b00) grant_seq.push_back(grant);
    prev_grant = grant;

    if (rst_arm && md_data && md_beats == 1 && md_len == 3) begin
      rst = 1'b1;
      #1;
      check_val("rst_grant", grant, 2'b00);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_s_rready", s_rready, 1'b0);
      check_val("rst_m_rvalid", m_rvalid, 2'b00);
      check_val("rst_len_err", len_err, 1'b0);
      reset_env();
      rst_arm = 1'b0; rst_hit = 1'b1;
      m_arvalid = 2'b00; m_rready = 2'b00; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      ar_hs = e_sarv && s_arready;
      r_hs  = md_data && s_rvalid && m_rready[o];
      if (md_owner < 0) begin
        if (m_arvalid == 2'b11) md_owner = 1 - md_last;
        else if (m_arvalid == 2'b01) md_owner = 0;
        else if (m_arvalid == 2'b10) md_owner = 1;
        else md_owner = -1;
        md_data = 1'b0;
      end else if (!md_data) begin
        if (ar_hs) begin
          md_data = 1'b1; md_beats = 0; md_len = mp_len[o];
        end
      end else if (r_hs) begin
        delivered = md_beats + 1;
        if (s_rlast) begin
          if (delivered != md_len + 1) md_err = 1'b1;
          md_last = o; md_owner = -1; md_data = 1'b0;
        end else if (delivered >= md_len + 1) begin
          md_err = 1'b1;
        end
        md_beats = delivered;
      end

      for (int i = 0; i < 2; i++) begin
        if (mp_pend[i] && m_arready[i]) begin
          mp_pend[i] = 1'b0; mb_addr[i] = mp_addr[i]; mb_beat[i] = 0;
        end
        if (m_rvalid[i] && m_rready[i]) begin
          check_val("sb_data", m_rdata, data_of(mb_addr[i], mb_beat[i]));
          last_data[i] = m_rdata; mb_beat[i]++; n_beats[i]++;
        end
      end
      if (s_arvalid && s_arready) begin
        sl_busy = 1'b1; sl_addr = s_araddr; sl_len = int'(s_arlen); sl_beat = 0;
        sl_early = inj_err && (s_arlen != 8'd0); sl_rv = 1'b0;
      end else if (sl_rv && s_rready) begin
        if (s_rlast) begin
          sl_busy = 1'b0;
          if (sl_early) err_done = 1'b1;
        end
        sl_beat++; sl_rv = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (!mp_pend[i] && req_mask[i] && roll(p_req)) begin
          mp_pend[i] = 1'b1;
          mp_addr[i] = $urandom() & 32'hFFFF_FFFC;
          mp_len[i]  = int'($urandom_range(max_len, min_len));
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    p_req = 0;
    while ((md_owner >= 0 || mp_pend[0] || mp_pend[1]) && k < 200) begin
      step();
      k++;
    end
    check_val(tag, (md_owner < 0) && !mp_pend[0] && !mp_pend[1], 1'b1);
  endtask

  initial begin
    int n0, n1, k, base0, base1;
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    m_arvalid = 2'b00; m_araddr = '0; m_arlen = '0; m_rready = 2'b00;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
    f_m_arvalid = 2'b00; f_m_araddr = {32'h0000_2000, 32'h0000_1000}; f_m_arlen = '0; f_m_rready = 2'b11;
    f_s_arready = 1'b1; f_s_rvalid = 1'b1; f_s_rdata = 32'h1234_5678; f_s_rresp = 2'b00; f_s_rlast = 1'b1;
    for (int i = 0; i < 2; i++) begin n_beats[i] = 0; last_data[i] = 32'h0; end
    reset_env();
    p_req = 0; p_rr = 100; p_sar = 100; p_sr = 100; min_len = 0; max_len = 0; req_mask = 2'b00;
    inj_err = 1'b0; rec_grants = 1'b0; rst_arm = 1'b0; rst_hit = 1'b0; err_done = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_val_grant", grant, 2'b00);
    check_val("rst_val_busy", busy, 1'b0);
    check_val("rst_val_len_err", len_err, 1'b0);
    check_val("rst_val_s_arvalid", s_arvalid, 1'b0);
    check_val("rst_val_ready_valid", {m_arready, m_rvalid, s_rready}, 5'b0);
    check_val("rst_val_fp_grant", f_grant, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // fixed-priority instance: instruction master wins every time it requests
    f_m_arvalid = 2'b11; n0 = 0; n1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (f_grant == 2'b01) n0++; else if (f_grant == 2'b10) n1++;
    end
    check_val("fp_data_never", n1, 0);
    check_val("fp_inst_served", n0 >= 6, 1'b1);
    k = 0;
    while (f_busy && k < 10) begin @(negedge clk); k++; end
    f_m_arvalid = 2'b10; n0 = 0; n1 = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); #1;
      if (f_grant == 2'b01) n0++; else if (f_grant == 2'b10) n1++;
    end
    check_val("fp_data_alone", n1 >= 4, 1'b1);
    check_val("fp_inst_absent", n0, 0);
    k = 0;
    while (f_busy && k < 10) begin @(negedge clk); k++; end
    f_m_arvalid = 2'b00;

    // round-robin with both masters requesting continuously
    p_req = 100; p_rr = 100; p_sar = 100; p_sr = 100; min_len = 0; max_len = 0;
    req_mask = 2'b11; rec_grants = 1'b1;
    repeat (30) step();
    rec_grants = 1'b0;
    check_val("rr_count", grant_seq.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < grant_seq.size(); i++)
      check_val($sformatf("rr_order%0d", i), grant_seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    drain("drain_rr");

    // single instruction read
    req_mask = 2'b00; base0 = n_beats[0];
    mp_pend[0] = 1'b1; mp_addr[0] = 32'h0000_0100; mp_len[0] = 0;
    repeat (10) step();
    check_val("single_beats", n_beats[0] - base0, 1);
    check_val("single_data", last_data[0], 32'hDEAD_BEEF);
    check_val("single_idle", grant, 2'b00);
    check_val("single_len_err", len_err, 1'b0);

    // random traffic with stalls and bursts
    base0 = n_beats[0]; base1 = n_beats[1];
    p_req = 30; p_rr = 70; p_sar = 60; p_sr = 60; min_len = 0; max_len = 3; req_mask = 2'b11;
    repeat (400) step();
    drain("drain_rand");
    check_val("rand_served", (n_beats[0] > base0) && (n_beats[1] > base1), 1'b1);

    // early RLAST on a two-beat burst
    req_mask = 2'b10; min_len = 1; max_len = 1; p_req = 100; inj_err = 1'b1; err_done = 1'b0;
    k = 0;
    while (!err_done && k < 200) begin step(); k++; end
    inj_err = 1'b0;
    check_val("lenerr_injected", err_done, 1'b1);
    repeat (2) step();
    check_val("lenerr_set", len_err, 1'b1);
    min_len = 0; max_len = 3; p_req = 30; req_mask = 2'b11;
    repeat (100) step();
    check_val("lenerr_sticky", len_err, 1'b1);
    drain("drain_err");

    // reset during beat 1 of a four-beat data burst, then a fresh request
    req_mask = 2'b10; min_len = 3; max_len = 3; p_req = 100; p_rr = 60; p_sr = 70;
    rst_arm = 1'b1; rst_hit = 1'b0; k = 0;
    while (!rst_hit && k < 300) begin step(); k++; end
    rst_arm = 1'b0;
    check_val("rst_reached", rst_hit, 1'b1);
    base1 = n_beats[1]; min_len = 0;
    repeat (40) step();
    check_val("post_rst_served", n_beats[1] > base1, 1'b1);
    check_val("post_rst_len_err", len_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
